// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between instruction fetch and load/store,
//            data-first with alternation; optional stall counters behind
//            the ARB_PERF_CNT_EN macro.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int DATA_W      = 32,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [DATA_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              err,
  output logic [31:0]       cnt_if_stall,
  output logic [31:0]       cnt_d_stall
);

  localparam int WAIT_W = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                last_d_q, last_d_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
  logic                if_valid_q, if_valid_d;
  logic                d_valid_q, d_valid_d;
  logic                err_q, err_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                d_pend;
  logic                timeout_hit;
  logic [DATA_W-1:0]   resp_data;

  assign d_pend      = d_read | d_write;
  assign timeout_hit = (ACK_TIMEOUT != 0) && (wait_q == WAIT_W'(ACK_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    last_d_d    = last_d_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;
    err_d       = err_q;
    wait_d      = wait_q;
    resp_data   = mem_ack ? mem_rdata : TIMEOUT_DATA;

    case (state_q)
      IDLE: begin
        // Data wins unless it won last time and a fetch is waiting.
        if (d_pend && (!last_d_q || !if_req)) begin
          state_d     = DBUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_write;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          last_d_d    = 1'b1;
          wait_d      = '0;
          if (d_read && d_write) err_d = 1'b1;
        end else if (if_req) begin
          state_d     = IBUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          last_d_d    = 1'b0;
          wait_d      = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (mem_ack || timeout_hit) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          if (!mem_ack) err_d = 1'b1;
          if (state_q == IBUSY) begin
            if_valid_d = 1'b1;
            if_rdata_d = resp_data;
          end else begin
            d_valid_d = 1'b1;
            if (!mem_we_q) d_rdata_d = resp_data;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_d_q    <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      err_q       <= 1'b0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_d_q    <= last_d_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_valid_q  <= if_valid_d;
      d_valid_q   <= d_valid_d;
      err_q       <= err_d;
      wait_q      <= wait_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign err       = err_q;

  // Stalls release in the valid cycle so the pipeline steps as RESP ends.
  assign stall_if  = if_req & ~if_valid_q;
  assign stall_mem = d_pend & ~d_valid_q;

`ifdef ARB_PERF_CNT_EN
  logic [31:0] cnt_if_q, cnt_if_d;
  logic [31:0] cnt_d_q, cnt_d_d;

  always_comb begin
    cnt_if_d = cnt_if_q;
    cnt_d_d  = cnt_d_q;
    if (stall_if && (cnt_if_q != 32'hFFFF_FFFF)) cnt_if_d = cnt_if_q + 32'd1;
    if (stall_mem && (cnt_d_q != 32'hFFFF_FFFF)) cnt_d_d = cnt_d_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_if_q <= '0;
      cnt_d_q  <= '0;
    end else begin
      cnt_if_q <= cnt_if_d;
      cnt_d_q  <= cnt_d_d;
    end
  end

  assign cnt_if_stall = cnt_if_q;
  assign cnt_d_stall  = cnt_d_q;
`else
  assign cnt_if_stall = '0;
  assign cnt_d_stall  = '0;
`endif

endmodule
`default_nettype wire
